// File: rtl/fdl_tune_ctrl.sv
// Closed-loop fine delay line tuning controller: filters PD votes, steps the FDL code,
// hands off to the coarse line at range ends. Optional build macro: FDL_LOCK_FREEZE_EN.
module fdl_tune_ctrl #(
    parameter int unsigned FILT_TH    = 4,
    parameter int unsigned ACC_W      = 5,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned LOCK_REV   = 4
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       en,
    input  logic       pd_up,
    input  logic       pd_dn,
    input  logic       cdl_ack,
    output logic [5:0] Q,
    output logic [2:0] level,
    output logic       cdl_inc,
    output logic       cdl_dec,
    output logic       locked
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned REV_W = $clog2(LOCK_REV + 1);
    localparam int unsigned SUM_W = ACC_W + 1;

    localparam logic [2:0]       LVL_MIN  = 3'd0;
    localparam logic [2:0]       LVL_MID  = 3'd3;
    localparam logic [2:0]       LVL_MAX  = 3'd6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [REV_W-1:0] REV_MAX  = REV_W'(LOCK_REV);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_TRACK   = 2'd2,
        S_HANDOFF = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [2:0]               level_q, level_d;
    logic [5:0]               code_q, code_d;
    logic                     inc_q, inc_d;
    logic                     dec_q, dec_d;
    logic                     locked_q, locked_d;
    logic [REV_W-1:0]         rev_q, rev_d;
    logic                     prev_vld_q, prev_vld_d;
    logic                     prev_up_q, prev_up_d;

    logic signed [SUM_W-1:0]  vote_c;
    logic signed [SUM_W-1:0]  acc_ext_c;
    logic signed [SUM_W-1:0]  acc_sum_c;
    logic signed [SUM_W-1:0]  th_c;
    logic                     step_up_c;
    logic                     step_dn_c;
    logic                     at_end_c;

    function automatic logic [5:0] level_to_code(input logic [2:0] lvl);
        case (lvl)
            3'd0:    return 6'b000000;
            3'd1:    return 6'b100000;
            3'd2:    return 6'b110000;
            3'd3:    return 6'b111000;
            3'd4:    return 6'b111100;
            3'd5:    return 6'b111110;
            default: return 6'b111111;
        endcase
    endfunction

    // Vote filter: a step fires on the edge the running sum reaches the threshold.
    always_comb begin
        vote_c = '0;
        if (pd_up && !pd_dn) begin
            vote_c = SUM_W'(1);
        end else if (pd_dn && !pd_up) begin
            vote_c = '1;
        end
        acc_ext_c = {acc_q[ACC_W-1], acc_q};
        acc_sum_c = acc_ext_c + vote_c;
`ifdef FDL_LOCK_FREEZE_EN
        th_c = locked_q ? SUM_W'(2 * FILT_TH) : SUM_W'(FILT_TH);
`else
        th_c = SUM_W'(FILT_TH);
`endif
        step_up_c = en && (state_q == S_TRACK) && (acc_sum_c >= th_c);
        step_dn_c = en && (state_q == S_TRACK) && (acc_sum_c <= -th_c);
        at_end_c  = step_up_c ? (level_q == LVL_MAX) : (level_q == LVL_MIN);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_SETTLE;
                S_SETTLE:  if (cnt_q == CNT_LAST) state_d = S_TRACK;
                S_TRACK: begin
                    if (step_up_c || step_dn_c) begin
                        state_d = at_end_c ? S_HANDOFF : S_SETTLE;
                    end
                end
                S_HANDOFF: if (cdl_ack) state_d = S_SETTLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        inc_d      = inc_q;
        dec_d      = dec_q;
        locked_d   = locked_q;
        rev_d      = rev_q;
        prev_vld_d = prev_vld_q;
        prev_up_d  = prev_up_q;
        if (!en) begin
            acc_d      = '0;
            cnt_d      = '0;
            inc_d      = 1'b0;
            dec_d      = 1'b0;
            locked_d   = 1'b0;
            rev_d      = '0;
            prev_vld_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    acc_d = '0;
                    cnt_d = '0;
                end
                S_SETTLE: begin
                    acc_d = '0;
                    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                end
                S_TRACK: begin
                    if (step_up_c || step_dn_c) begin
                        acc_d = '0;
                        if (at_end_c) begin
                            // Fine range exhausted: request a coarse step, restart lock search.
                            inc_d      = step_up_c;
                            dec_d      = step_dn_c;
                            rev_d      = '0;
                            locked_d   = 1'b0;
                            prev_vld_d = 1'b0;
                        end else begin
                            level_d = step_up_c ? level_q + 3'd1 : level_q - 3'd1;
                            if (prev_vld_q) begin
                                if (prev_up_q != step_up_c) begin
                                    if (rev_q != REV_MAX) rev_d = rev_q + REV_W'(1);
                                    if (rev_d == REV_MAX) locked_d = 1'b1;
                                end else begin
                                    rev_d    = '0;
                                    locked_d = 1'b0;
                                end
                            end
                            prev_vld_d = 1'b1;
                            prev_up_d  = step_up_c;
                        end
                    end else begin
                        acc_d = acc_sum_c[ACC_W-1:0];
                    end
                end
                S_HANDOFF: begin
                    if (cdl_ack) begin
                        inc_d   = 1'b0;
                        dec_d   = 1'b0;
                        level_d = LVL_MID;
                    end
                end
                default: begin
                    acc_d = '0;
                end
            endcase
        end
        code_d = level_to_code(level_d);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            level_q    <= LVL_MID;
            code_q     <= 6'b111000;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            locked_q   <= 1'b0;
            rev_q      <= '0;
            prev_vld_q <= 1'b0;
            prev_up_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            code_q     <= code_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            locked_q   <= locked_d;
            rev_q      <= rev_d;
            prev_vld_q <= prev_vld_d;
            prev_up_q  <= prev_up_d;
        end
    end

    assign Q       = code_q;
    assign level   = level_q;
    assign cdl_inc = inc_q;
    assign cdl_dec = dec_q;
    assign locked  = locked_q;

endmodule

// File: tb/tb_fdl_tune_ctrl.sv
// Bench for fdl_tune_ctrl: behavioural model checked every cycle plus directed literal checks.
module tb_fdl_tune_ctrl;

    localparam int FILT_TH    = 4;
    localparam int SETTLE_CYC = 8;
    localparam int LOCK_REV   = 4;
`ifdef FDL_LOCK_FREEZE_EN
    localparam int TH_LOCKED  = 2 * FILT_TH;
`else
    localparam int TH_LOCKED  = FILT_TH;
`endif

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       pd_up = 1'b0;
    logic       pd_dn = 1'b0;
    logic       cdl_ack = 1'b0;
    logic [5:0] Q;
    logic [2:0] level;
    logic       cdl_inc;
    logic       cdl_dec;
    logic       locked;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_in = ~clk_in;

    fdl_tune_ctrl #(
        .FILT_TH   (FILT_TH),
        .ACC_W     (5),
        .SETTLE_CYC(SETTLE_CYC),
        .LOCK_REV  (LOCK_REV)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (en),
        .pd_up  (pd_up),
        .pd_dn  (pd_dn),
        .cdl_ack(cdl_ack),
        .Q      (Q),
        .level  (level),
        .cdl_inc(cdl_inc),
        .cdl_dec(cdl_dec),
        .locked (locked)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] q_of(input int lvl);
        logic [5:0] q;
        q = '0;
        for (int i = 0; i < lvl; i++) q[5-i] = 1'b1;
        return q;
    endfunction

    // Model: level, vote sum, settle countdown, pending coarse request and lock history.
    bit m_valid = 1'b0;
    bit m_active;
    bit m_locked;
    int m_level, m_acc, m_settle, m_req, m_last, m_rev;
    int mv_vote, mv_th, mv_dir, mv_nl;

    always @(posedge clk_in) begin
        if (rst) begin
            m_valid = 1'b1; m_active = 1'b0; m_locked = 1'b0;
            m_level = 3; m_acc = 0; m_settle = 0; m_req = 0; m_last = 0; m_rev = 0;
        end else if (!en) begin
            m_active = 1'b0; m_locked = 1'b0;
            m_acc = 0; m_settle = 0; m_req = 0; m_last = 0; m_rev = 0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_settle = SETTLE_CYC;
            m_acc    = 0;
        end else if (m_req != 0) begin
            if (cdl_ack) begin
                m_req    = 0;
                m_level  = 3;
                m_settle = SETTLE_CYC;
            end
        end else if (m_settle > 0) begin
            m_settle--;
        end else begin
            mv_vote = (pd_up && !pd_dn) ? 1 : ((pd_dn && !pd_up) ? -1 : 0);
            mv_th   = FILT_TH;
`ifdef FDL_LOCK_FREEZE_EN
            if (m_locked) mv_th = 2 * FILT_TH;
`endif
            m_acc += mv_vote;
            if (m_acc >= mv_th || m_acc <= -mv_th) begin
                mv_dir = (m_acc > 0) ? 1 : -1;
                m_acc  = 0;
                mv_nl  = m_level + mv_dir;
                if (mv_nl < 0 || mv_nl > 6) begin
                    m_req = mv_dir; m_rev = 0; m_locked = 1'b0; m_last = 0;
                end else begin
                    m_level  = mv_nl;
                    m_settle = SETTLE_CYC;
                    if (m_last != 0) begin
                        if (mv_dir != m_last) begin
                            if (m_rev < LOCK_REV) m_rev++;
                            if (m_rev == LOCK_REV) m_locked = 1'b1;
                        end else begin
                            m_rev = 0; m_locked = 1'b0;
                        end
                    end
                    m_last = mv_dir;
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (m_valid) begin
            check("model_Q",       Q,       q_of(m_level));
            check("model_level",   level,   m_level);
            check("model_cdl_inc", cdl_inc, m_req == 1);
            check("model_cdl_dec", cdl_dec, m_req == -1);
            check("model_locked",  locked,  m_locked);
            check("inc_dec_excl",  cdl_inc & cdl_dec, 1'b0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // sel: 0 = wait for cdl_inc, 1 = wait for cdl_dec
    task automatic wait_req(input string name, input int sel, input int budget);
        int k;
        k = 0;
        while (((sel == 0) ? cdl_inc : cdl_dec) !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        if (((sel == 0) ? cdl_inc : cdl_dec) !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: request not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic step_dir(input string name, input bit up, output int cycles);
        logic [2:0] l0;
        l0 = level;
        cycles = 0;
        pd_up = up;
        pd_dn = !up;
        while (level === l0 && cycles < 40) begin
            tick(1);
            cycles++;
        end
        pd_up = 1'b0;
        pd_dn = 1'b0;
        if (level === l0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no step within 40 cycles, level %0d", name, level);
        end
    endtask

    initial begin
        int c;
        // Reset and idle with PD activity.
        tick(2);
        check("rst_Q", Q, 6'b111000);
        check("rst_level", level, 3'd3);
        check("rst_inc", cdl_inc, 1'b0);
        check("rst_dec", cdl_dec, 1'b0);
        check("rst_locked", locked, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pd_up = ~pd_up;
            pd_dn = (i % 3 == 0);
            tick(1);
        end
        check("idle_Q", Q, 6'b111000);
        pd_up = 1'b0;
        pd_dn = 1'b0;

        // Settle then a single up step on the 4th tracking edge.
        en = 1'b1;
        pd_up = 1'b1;
        tick(12);
        check("pre_step_Q", Q, 6'b111000);
        tick(1);
        check("first_step_Q", Q, 6'b111100);
        check("first_step_level", level, 3'd4);
        tick(8);
        check("settle_hold_Q", Q, 6'b111100);

        // Up handoff and recentre.
        wait_req("up_handoff", 0, 100);
        check("top_Q", Q, 6'b111111);
        tick(3);
        check("inc_held", cdl_inc, 1'b1);
        cdl_ack = 1'b1;
        tick(1);
        cdl_ack = 1'b0;
        check("inc_release", cdl_inc, 1'b0);
        check("recentre_up_Q", Q, 6'b111000);

        // Down handoff from level 0.
        pd_up = 1'b0;
        pd_dn = 1'b1;
        wait_req("dn_handoff", 1, 200);
        check("bottom_Q", Q, 6'b000000);
        check("dn_no_inc", cdl_inc, 1'b0);
        tick(2);
        cdl_ack = 1'b1;
        tick(1);
        cdl_ack = 1'b0;
        pd_dn = 1'b0;
        check("dec_release", cdl_dec, 1'b0);
        check("recentre_dn_Q", Q, 6'b111000);

        // Lock after four reversals.
        step_dir("lk1", 1'b1, c);
        step_dir("lk2", 1'b0, c);
        step_dir("lk3", 1'b1, c);
        step_dir("lk4", 1'b0, c);
        check("lock_pre", locked, 1'b0);
        step_dir("lk5", 1'b1, c);
        check("lock_set", locked, 1'b1);
        check("lock_level", level, 3'd4);

        // Votes per step while locked.
        tick(10);
        step_dir("th_lock", 1'b0, c);
        check("votes_per_step", c, TH_LOCKED);
        check("lock_kept", locked, 1'b1);
        step_dir("up_a", 1'b1, c);
        step_dir("up_b", 1'b1, c);
        check("lock_drop", locked, 1'b0);
        check("lock_drop_level", level, 3'd5);

        // Ambiguous votes never step.
        pd_up = 1'b1;
        pd_dn = 1'b1;
        tick(20);
        check("ambig_level", level, 3'd5);
        pd_dn = 1'b0;

        // Abort a handoff with en.
        wait_req("abort_handoff", 0, 80);
        en = 1'b0;
        tick(1);
        pd_up = 1'b0;
        check("abort_inc", cdl_inc, 1'b0);
        check("abort_Q", Q, 6'b111111);

        // Ack outside handoff is ignored.
        en = 1'b1;
        cdl_ack = 1'b1;
        tick(12);
        cdl_ack = 1'b0;
        check("ack_ignored_Q", Q, 6'b111111);

        // Reset during handoff drops the request immediately.
        pd_up = 1'b1;
        wait_req("rst_handoff", 0, 40);
        rst = 1'b1;
        tick(1);
        check("rst_mid_inc", cdl_inc, 1'b0);
        check("rst_mid_Q", Q, 6'b111000);
        rst = 1'b0;
        en = 1'b0;
        pd_up = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
